// File: rtl/wei_burst_sched.sv
// Round-robin weight burst scheduler: streams cfg_len words per grant
// from the weight buffer to one of 16 PE blocks over valid/ready.
module wei_burst_sched #(
    parameter int PE_BLOCK = 16,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 12,
    parameter int LEN_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pull_back,
    input  logic [ADDR_W-1:0]   cfg_base,
    input  logic [LEN_W-1:0]    cfg_len,
    input  logic [PE_BLOCK-1:0] req_all,
    input  logic [PE_BLOCK-1:0] rdy_all,
    output logic                wbuf_rd_en,
    output logic [ADDR_W-1:0]   wbuf_rd_addr,
    input  logic [DATA_W-1:0]   wbuf_rd_data,
    output logic [PE_BLOCK-1:0] wei_val_all,
    output logic [DATA_W-1:0]   wei_data,
    output logic [3:0]          cur_peb,
    output logic                busy,
    output logic                burst_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_RUN, S_DRAIN, S_DONE
    } state_e;

    localparam logic [LEN_W:0] CNT_ONE = 1;

    state_e              state_q, state_d;
    logic [3:0]          last_q, last_d;
    logic [3:0]          cur_q, cur_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W:0]      iss_q, iss_d;
    logic [LEN_W:0]      dlv_q, dlv_d;
    logic [ADDR_W-1:0]   ptr_q [PE_BLOCK];
    logic [ADDR_W-1:0]   ptr_d [PE_BLOCK];
    logic                init_q, init_d;
    logic                rdv_q, rdv_d;
    logic [DATA_W-1:0]   mem_q [2];
    logic [DATA_W-1:0]   mem_d [2];
    logic                wp_q, wp_d;
    logic                rp_q, rp_d;
    logic [1:0]          cnt_q, cnt_d;

    logic [3:0]          win;
    logic                found;
    logic                pop;
    logic                rd_en;
    logic [1:0]          credits;
    logic [ADDR_W-1:0]   rd_addr;

    // Rotating priority: first requester after the last grant wins.
    always_comb begin
        win   = last_q;
        found = 1'b0;
        for (int i = 1; i <= PE_BLOCK; i++) begin
            if (!found && req_all[last_q + 4'(i)]) begin
                win   = last_q + 4'(i);
                found = 1'b1;
            end
        end
    end

    // A same-cycle pop frees a slot, keeping one word per cycle flowing.
    assign pop     = (cnt_q != 2'd0) && rdy_all[cur_q];
    assign credits = cnt_q + {1'b0, rdv_q};
    assign rd_en   = (state_q == S_RUN) && ((credits < 2'd2) || pop);
    assign rd_addr = ptr_q[cur_q] + ADDR_W'(iss_q);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cur_d   = cur_q;
        len_d   = len_q;
        iss_d   = iss_q;
        dlv_d   = dlv_q;
        ptr_d   = ptr_q;
        init_d  = 1'b0;
        rdv_d   = rd_en;
        mem_d   = mem_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        cnt_d   = cnt_q + {1'b0, rdv_q} - {1'b0, pop};

        if (rdv_q) begin
            mem_d[wp_q] = wbuf_rd_data;
            wp_d        = ~wp_q;
        end
        if (pop) begin
            rp_d  = ~rp_q;
            dlv_d = dlv_q + CNT_ONE;
        end
        if (rd_en) begin
            iss_d = iss_q + CNT_ONE;
        end
        if (init_q) begin
            for (int i = 0; i < PE_BLOCK; i++) ptr_d[i] = cfg_base;
        end

        unique case (state_q)
            S_IDLE: begin
                if (req_all != '0) state_d = S_ARB;
            end
            S_ARB: begin
                cur_d   = win;
                last_d  = win;
                len_d   = cfg_len;
                iss_d   = '0;
                dlv_d   = '0;
                state_d = (cfg_len == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (iss_d == {1'b0, len_q}) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (dlv_d == {1'b0, len_q}) state_d = S_DONE;
            end
            S_DONE: begin
                ptr_d[cur_q] = ptr_q[cur_q] + ADDR_W'(len_q);
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (pull_back) begin
            state_d = S_IDLE;
            last_d  = 4'hF;
            rdv_d   = 1'b0;
            wp_d    = 1'b0;
            rp_d    = 1'b0;
            cnt_d   = 2'd0;
            for (int i = 0; i < PE_BLOCK; i++) ptr_d[i] = cfg_base;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            last_q  <= 4'hF;
            cur_q   <= '0;
            len_q   <= '0;
            iss_q   <= '0;
            dlv_q   <= '0;
            init_q  <= 1'b1;
            rdv_q   <= 1'b0;
            wp_q    <= 1'b0;
            rp_q    <= 1'b0;
            cnt_q   <= '0;
            for (int i = 0; i < PE_BLOCK; i++) ptr_q[i] <= '0;
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cur_q   <= cur_d;
            len_q   <= len_d;
            iss_q   <= iss_d;
            dlv_q   <= dlv_d;
            init_q  <= init_d;
            rdv_q   <= rdv_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            mem_q   <= mem_d;
        end
    end

    assign wbuf_rd_en   = rd_en;
    assign wbuf_rd_addr = rd_en ? rd_addr : '0;
    assign wei_data     = mem_q[rp_q];
    assign wei_val_all  = (cnt_q != 2'd0)
                        ? ({{(PE_BLOCK-1){1'b0}}, 1'b1} << cur_q)
                        : '0;
    assign cur_peb      = cur_q;
    assign busy         = (state_q != S_IDLE);
    assign burst_done   = (state_q == S_DONE) && !pull_back;

endmodule
